// File: rtl/uart_arb_pkg.sv
// uart_tx_arbiter shared types: FSM encoding, baud codes, grant width.
package uart_arb_pkg;

    localparam int GRANT_W = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_WAIT = 2'd2;
    localparam state_t ST_GAP  = 2'd3;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or above
// rr_ptr, wrapping around; returns one-hot and binary grant.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [GRANT_W-1:0] grant_idx
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = GRANT_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_send among NUM_REQ byte sources.
// Optional WAIT watchdog: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int          NUM_REQ        = 4,
    parameter logic [2:0]  BAUD_SEL       = BAUD_9600,
    parameter int          GAP_CYCLES     = 16,
    parameter int          TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                 clk_50mhz,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_en,
    output logic [7:0]           uart_data,
    output logic [2:0]           uart_baud,
    input  logic                 uart_tx_done,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic                 err_timeout
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_chk
        $error("uart_tx_arbiter: parameter out of range");
    end

    localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [GW-1:0] GAP_END = GW'(GAP_LAST);
    localparam state_t AFTER_WAIT = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    state_t state, state_n;

    logic [NUM_REQ-1:0] grant_oh;
    logic [GRANT_W-1:0] grant_idx;
    logic [GRANT_W-1:0] rr_ptr;
    logic [GRANT_W-1:0] ptr_next;
    logic [GW-1:0]      gap_cnt;
    logic [7:0]         sel_byte;
    logic               any_req;
    logic               expire;
    logic               wait_end;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant_oh),
        .grant_idx (grant_idx)
    );

    assign uart_baud = BAUD_SEL;
    assign any_req   = |req_valid;

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i])
                sel_byte = sel_byte | req_data[8*i +: 8];
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_END = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] wait_cnt;

    // tx_done has priority over a coinciding expiry
    assign expire = (state == ST_WAIT) && !uart_tx_done
                  && (wait_cnt == TO_END);

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= expire;
            if (state != ST_WAIT)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign expire      = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign wait_end = (state == ST_WAIT) && (uart_tx_done || expire);
    assign ptr_next = (grant_id == GRANT_W'(NUM_REQ - 1))
                    ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: if (any_req) state_n = ST_LOAD;
            ST_LOAD: state_n = ST_WAIT;
            ST_WAIT: if (wait_end) state_n = AFTER_WAIT;
            ST_GAP:  if (gap_cnt == GAP_END) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        req_ready = (state == ST_IDLE) ? grant_oh : '0;
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            uart_en   <= 1'b0;
            uart_data <= 8'h00;
            grant_id  <= '0;
            gap_cnt   <= '0;
        end else begin
            uart_en <= (state_n == ST_LOAD);
            if (state == ST_IDLE && any_req) begin
                uart_data <= sel_byte;
                grant_id  <= grant_idx;
            end
            if (wait_end)
                rr_ptr <= ptr_next;
            if (state != ST_GAP)
                gap_cnt <= '0;
            else
                gap_cnt <= gap_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter; frames are scored against
// an expected-frame queue filled as requests are driven.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int N   = 4;
    localparam int GAP = 16;
    localparam int TO  = 50;

    logic           clk_50mhz = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           uart_en;
    logic [7:0]     uart_data;
    logic [2:0]     uart_baud;
    logic           uart_tx_done = 1'b0;
    logic           busy;
    logic [2:0]     grant_id;
    logic           err_timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic [2:0] gid;
    } exp_t;

    exp_t sb[$];

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .BAUD_SEL       (BAUD_9600),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_50mhz    (clk_50mhz),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .uart_en      (uart_en),
        .uart_data    (uart_data),
        .uart_baud    (uart_baud),
        .uart_tx_done (uart_tx_done),
        .busy         (busy),
        .grant_id     (grant_id),
        .err_timeout  (err_timeout)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    always @(negedge clk_50mhz) begin
        exp_t e;
        if (rst_n && uart_en) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: uart_en with data=%h grant=%0d, none expected",
                         uart_data, grant_id);
            end else begin
                e = sb.pop_front();
                if (uart_data !== e.data || grant_id !== e.gid) begin
                    errors++;
                    $display("FAIL sb_frame: got data=%h grant=%0d, expected data=%h grant=%0d",
                             uart_data, grant_id, e.data, e.gid);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy=%b after %0d cycles, expected 0", tag, busy, n);
        end
    endtask

    task automatic finish_frame(input string tag);
        uart_tx_done = 1'b1;
        tick();
        uart_tx_done = 1'b0;
        wait_idle(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        uart_tx_done = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0;
        tick();
        tick();
        checks++;
        if (uart_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_ctl: en=%b busy=%b, expected 0 0", uart_en, busy);
        end
        checks++;
        if (uart_data !== 8'h00 || grant_id !== 3'd0) begin
            errors++;
            $display("FAIL rst_data: data=%h grant=%0d, expected 00 0", uart_data, grant_id);
        end
        checks++;
        if (req_ready !== 4'b0000 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready: ready=%b err=%b, expected 0000 0", req_ready, err_timeout);
        end
        checks++;
        if (uart_baud !== 3'd0) begin
            errors++;
            $display("FAIL baud: got %0d, expected 0", uart_baud);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int n;
        req_data = '0;
        req_data[23:16] = 8'hA5;
        req_valid = 4'b0100;
        sb.push_back('{8'hA5, 3'd2});
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b, expected 0100", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (uart_en !== 1'b1 || uart_data !== 8'hA5 || grant_id !== 3'd2) begin
            errors++;
            $display("FAIL single_load: en=%b data=%h grant=%0d, expected 1 a5 2",
                     uart_en, uart_data, grant_id);
        end
        tick();
        checks++;
        if (uart_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_pulse: en=%b busy=%b, expected 0 1", uart_en, busy);
        end
        repeat (98) tick();
        checks++;
        if (uart_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_hold: data=%h, expected a5", uart_data);
        end
        uart_tx_done = 1'b1;
        tick();
        uart_tx_done = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != GAP) begin
            errors++;
            $display("FAIL single_gap: busy fell after %0d cycles, expected %0d", n, GAP);
        end
    endtask

    task automatic test_all_four();
        do_reset();
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 5; k++)
            sb.push_back('{8'h10 + 8'(k % 4), 3'(k % 4)});
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [N-1:0] exp_rdy;
            exp_rdy = 4'b0001 << (k % 4);
            #1;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rr_ready[%0d]: got %b, expected %b", k, req_ready, exp_rdy);
            end
            tick();
            tick();
            finish_frame("rr_frame");
        end
        req_valid = '0;
    endtask

    task automatic test_wrap_skip();
        req_data = {8'h33, 8'h32, 8'h31, 8'h30};
        req_valid = 4'b1000;
        sb.push_back('{8'h33, 3'd3});
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_r3: got %b, expected 1000", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
        finish_frame("wrap_f3");
        req_valid = 4'b1010;
        sb.push_back('{8'h31, 3'd1});
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL wrap_skip: got %b, expected 0010", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
        finish_frame("wrap_f1");
    endtask

    task automatic test_spurious();
        int bad_rdy;
        int bad_busy;
        bad_rdy = 0;
        bad_busy = 0;
        uart_tx_done = 1'b1;
        tick();
        uart_tx_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || uart_en !== 1'b0) begin
            errors++;
            $display("FAIL spur_idle: busy=%b en=%b, expected 0 0", busy, uart_en);
        end
        req_data[7:0] = 8'h5A;
        req_valid = 4'b0001;
        sb.push_back('{8'h5A, 3'd0});
        tick();
        req_valid = '0;
        uart_tx_done = 1'b1;
        tick();
        uart_tx_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            req_valid = 4'($urandom_range(1, 15));
            #1;
            if (req_ready !== 4'b0000) bad_rdy++;
            if (busy !== 1'b1) bad_busy++;
            tick();
        end
        req_valid = '0;
        checks++;
        if (bad_rdy != 0) begin
            errors++;
            $display("FAIL spur_ready: %0d cycles with ready in WAIT, expected 0", bad_rdy);
        end
        checks++;
        if (bad_busy != 0) begin
            errors++;
            $display("FAIL spur_load: %0d cycles not busy in WAIT, expected 0", bad_busy);
        end
        finish_frame("spur_frame");
    endtask

    task automatic test_reset_mid();
        req_data[23:16] = 8'hC3;
        req_valid = 4'b0100;
        sb.push_back('{8'hC3, 3'd2});
        tick();
        req_valid = '0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (uart_en !== 1'b0 || busy !== 1'b0 || grant_id !== 3'd0 || uart_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_rst: en=%b busy=%b grant=%0d data=%h, expected 0 0 0 00",
                     uart_en, busy, grant_id, uart_data);
        end
        tick();
        rst_n = 1'b1;
        req_data[7:0] = 8'hD0;
        req_valid = 4'b1111;
        sb.push_back('{8'hD0, 3'd0});
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_ptr: ready=%b, expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
        finish_frame("mid_frame");
    endtask

    task automatic test_timeout();
        int n;
        req_data[15:8] = 8'hE1;
        req_valid = 4'b0010;
        sb.push_back('{8'hE1, 3'd1});
        tick();
        req_valid = '0;
        tick();
`ifdef UART_ARB_TIMEOUT_EN
        n = 0;
        while (err_timeout !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n != TO) begin
            errors++;
            $display("FAIL to_delay: err_timeout after %0d cycles, expected %0d", n, TO);
        end
        tick();
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL to_pulse: err=%b busy=%b, expected 0 1", err_timeout, busy);
        end
        wait_idle("to_gap");
`else
        n = 0;
        repeat (200) begin
            tick();
            if (busy !== 1'b1 || err_timeout !== 1'b0) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL no_to: %0d cycles left WAIT or raised err, expected 0", n);
        end
        do_reset();
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_wrap_skip();
        test_spurious();
        test_reset_mid();
        test_timeout();
        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d frames never sent, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one uart_send instance among NUM_REQ byte requesters.
- Accepts one byte per valid/ready handshake and drives uart_send's one-cycle en pulse with a stable data byte.
- Waits for uart_send's tx_done, then inserts a programmable idle gap before the next frame.
- Sits between several producers (key handlers, ISSP sources, status reporters) and the single TX line.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BAUD_SEL, 3'd0, constant baud code driven to uart_send.
- GAP_CYCLES, 16, idle clock cycles inserted after each tx_done (0 allowed).
- TIMEOUT_CYCLES, 2_000_000, WAIT watchdog limit; used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk_50mhz  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  NUM_REQ*8  packed bytes; requester i occupies [8i+7:8i].
- req_ready  output  NUM_REQ  per-requester accept; a transfer occurs when valid && ready in the same cycle.
- uart_en  output  1  one-cycle start pulse to uart_send en.
- uart_data  output  8  byte to uart_send data; held stable from en until tx_done.
- uart_baud  output  3  equals BAUD_SEL.
- uart_tx_done  input  1  tx_done pulse from uart_send.
- busy  output  1  high in every state except IDLE.
- grant_id  output  3  index of the requester owning the current frame.
- err_timeout  output  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0, uart_en=0, uart_data=8'h00, grant_id=0, busy=0, err_timeout=0, gap counter=0.
  - req_ready is combinational from state, so it is 0 whenever no request is valid.
- States and transitions:
  - IDLE: grant = first set bit of req_valid, searching from rr_ptr upward with wrap-around. req_ready[grant]=1 combinationally; all other req_ready bits are 0. If any req_valid is set, latch req_data[grant] into uart_data and grant into grant_id at the clock edge, then go to LOAD. If none is set, stay in IDLE and hold req_ready=0.
  - LOAD: exactly one cycle. uart_en=1 (registered Moore output), then go to WAIT.
  - WAIT: uart_en=0 and uart_data held. On uart_tx_done=1: rr_ptr <= (grant_id+1) mod NUM_REQ, then go to GAP if GAP_CYCLES>0, else to IDLE.
  - GAP: counter runs 0..GAP_CYCLES-1, then go to IDLE. Counter clears on entry.
- Latency:
  - req_valid seen in IDLE in cycle 0 -> req_ready in cycle 0 -> uart_en in cycle 1.
  - Minimum frame-to-frame spacing is tx_done + GAP_CYCLES + 1 cycles.
- Fairness:
  - After requester i is served, i has lowest priority for the next arbitration.
  - With all requesters continuously valid, grants cycle 0,1,2,...,NUM_REQ-1,0.
- Boundaries:
  - uart_tx_done outside WAIT is ignored.
  - req_valid changes outside IDLE are ignored; no req_ready is issued.
  - A requester dropping valid before being granted is simply skipped.
  - Multiple simultaneous valids: only one is granted per IDLE cycle.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Reset asserted mid-frame forces IDLE immediately. The in-flight byte is abandoned, and uart_send is reset by the same rst_n.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter clears on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES-1 without uart_tx_done, err_timeout pulses for 1 cycle, rr_ptr advances as if done, and the FSM goes to GAP.
  - If tx_done and expiry coincide, tx_done wins and no error pulse is raised.
- Undefined:
  - No counter is built; WAIT lasts indefinitely until tx_done.
  - err_timeout is tied to 0.

Decomposition:
- Shared package uart_arb_pkg:
  - state encoding localparams: ST_IDLE, ST_LOAD, ST_WAIT, ST_GAP.
  - baud code constants BAUD_9600=3'd0 through BAUD_115200=3'd4.
  - width helper constant for grant_id.
- One sub-module, rr_arbiter:
  - inputs: req vector and rr_ptr.
  - outputs: one-hot grant and binary grant index.
  - purely combinational.

Test Plan:
- Reset then single requester: NUM_REQ=4, req_valid=4'b0100, req_data[23:16]=8'hA5.
  - req_ready=4'b0100 in the same cycle, uart_en is high exactly 1 cycle on the next cycle, uart_data=8'hA5, grant_id=2.
  - Model tx_done after 100 cycles -> busy falls 16 cycles later.
- All four valid continuously with bytes 8'h10/8'h11/8'h12/8'h13 -> transmitted order 10,11,12,13,10, with a one-hot req_ready for each grant.
- Ptr wrap and skip: serve requester 3, then present req_valid=4'b1010 -> next grant is 1 (wrap past 3 to 0, first set bit is 1).
- Spurious inputs:
  - uart_tx_done pulsed during IDLE and LOAD -> no state change.
  - req_valid toggled during WAIT -> req_ready stays 0.
- Reset mid-frame: assert rst_n=0 during WAIT -> uart_en=0, busy=0, rr_ptr=0 asynchronously; after release, req_valid=4'b1111 grants requester 0.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=50, never send tx_done:
  - err_timeout pulses 50 cycles after entering WAIT, followed by the GAP and then IDLE.
  - Without the macro: busy stays 1 and err_timeout stays 0.
